// File: rtl/fir_seq_pkg.sv
// Shared constants, FSM encoding and output rounding/saturation for the
// time-multiplexed symmetric FIR sequencer.
package fir_seq_pkg;

    localparam int NUM_TAPS = 147;
    localparam int HALF     = (NUM_TAPS + 1) / 2;
    localparam int DATA_W   = 16;
    localparam int COEF_W   = 16;
    localparam int ACC_W    = 46;
    localparam int SHIFT    = 15;
    localparam int PTR_W    = 8;
    localparam int K_W      = 7;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t MAC   = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t OUT   = 2'd3;

    localparam logic [ACC_W:0] ROUND_CONST = (ACC_W + 1)'(1) << (SHIFT - 1);

    // Round half up, then clamp to the signed DATA_W range instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] rounded;
        rounded = $signed({acc[ACC_W-1], acc} + ROUND_CONST) >>> SHIFT;
        if ((&rounded[ACC_W:DATA_W-1]) || !(|rounded[ACC_W:DATA_W-1]))
            sat_round = rounded[DATA_W-1:0];
        else if (rounded[ACC_W])
            sat_round = {1'b1, {(DATA_W-1){1'b0}}};
        else
            sat_round = {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes always land in the shadow bank,
// and a requested swap is deferred until the sequencer is idle.
module fir_coef_bank
    import fir_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [K_W-1:0]    wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              swap_req,
    input  logic              in_idle,
    input  logic [K_W-1:0]    rd_addr,
    output logic [COEF_W-1:0] rd_data,
    output logic              bank
);

    logic [COEF_W-1:0] mem [0:1][0:HALF-1];
    logic              swap_pending;
    logic              do_swap;

    assign do_swap = in_idle && swap_pending;
    assign rd_data = mem[bank][rd_addr];

    // A write coinciding with the swap edge still targets the old shadow bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank         <= 1'b0;
            swap_pending <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < HALF; i++)
                    mem[b][i] <= '0;
        end else begin
            if (wr_en && (wr_addr < K_W'(HALF)))
                mem[~bank][wr_addr] <= wr_data;
            if (do_swap) begin
                bank         <= ~bank;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Symmetric FIR engine sharing one multiplier across all coefficient pairs,
// with a circular sample history and a two-stage pair-add/MAC pipeline.
module fir_mac_sequencer
    import fir_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    input  logic              coef_wr_en,
    input  logic [6:0]        coef_wr_addr,
    input  logic [COEF_W-1:0] coef_wr_data,
    input  logic              coef_swap,
    output logic              coef_bank,
    output logic              busy
);

    state_t                          state;
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W-1:0]                rd_a;
    logic [PTR_W-1:0]                rd_b;
    logic [K_W-1:0]                  k;
    logic                            drain_cnt;
    logic [DATA_W-1:0]               hist [0:NUM_TAPS-1];
    logic signed [DATA_W:0]          pair_sum;
    logic signed [DATA_W:0]          pair_r;
    logic signed [COEF_W-1:0]        coef_r;
    logic signed [DATA_W+COEF_W:0]   product;
    logic                            s1_valid;
    logic signed [ACC_W-1:0]         acc;
    logic [DATA_W-1:0]               m_data_r;
    logic [COEF_W-1:0]               coef_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_TAPS - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(NUM_TAPS - 1) : p - 1'b1;
    endfunction

    assign s_ready = rst_n && (state == IDLE);
    assign m_valid = rst_n && (state == OUT);
    assign busy    = (state != IDLE);
    assign m_data  = m_data_r;

    fir_coef_bank u_coef_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (coef_wr_en),
        .wr_addr  (coef_wr_addr),
        .wr_data  (coef_wr_data),
        .swap_req (coef_swap),
        .in_idle  (state == IDLE),
        .rd_addr  (k),
        .rd_data  (coef_rd),
        .bank     (coef_bank)
    );

    // The two taps of the centre index alias the same history slot, so it is used once.
    always_comb begin
        if (k == K_W'(HALF - 1))
            pair_sum = {hist[rd_a][DATA_W-1], hist[rd_a]};
        else
            pair_sum = $signed({hist[rd_a][DATA_W-1], hist[rd_a]})
                     + $signed({hist[rd_b][DATA_W-1], hist[rd_b]});
    end

    assign product = pair_r * coef_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_a      <= '0;
            rd_b      <= '0;
            k         <= '0;
            drain_cnt <= 1'b0;
            pair_r    <= '0;
            coef_r    <= '0;
            s1_valid  <= 1'b0;
            acc       <= '0;
            m_data_r  <= '0;
            for (int i = 0; i < NUM_TAPS; i++)
                hist[i] <= '0;
        end else begin
            s1_valid <= 1'b0;
            if (s1_valid)
                acc <= acc + {{(ACC_W-DATA_W-COEF_W-1){product[DATA_W+COEF_W]}}, product};
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        hist[wr_ptr] <= s_data;
                        wr_ptr       <= ptr_inc(wr_ptr);
                        rd_a         <= wr_ptr;
                        rd_b         <= ptr_inc(wr_ptr);
                        k            <= '0;
                        acc          <= '0;
                        state        <= MAC;
                    end
                end
                MAC: begin
                    pair_r   <= pair_sum;
                    coef_r   <= coef_rd;
                    s1_valid <= 1'b1;
                    rd_a     <= ptr_dec(rd_a);
                    rd_b     <= ptr_inc(rd_b);
                    k        <= k + 1'b1;
                    if (k == K_W'(HALF - 1)) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) begin
                        m_data_r <= sat_round(acc);
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed, table-driven bench for fir_mac_sequencer with hand-computed
// impulse, saturation, swap, backpressure and reset expectations.
module tb_fir_mac_sequencer;
    import fir_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [15:0]       s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [15:0]       m_data;
    logic              coef_wr_en = 1'b0;
    logic [6:0]        coef_wr_addr = '0;
    logic [15:0]       coef_wr_data = '0;
    logic              coef_swap = 1'b0;
    logic              coef_bank;
    logic              busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] sample;
        logic [15:0] expect_y;
        bit          check;
    } vec_t;

    vec_t vecs [0:293];

    fir_mac_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .coef_swap    (coef_swap),
        .coef_bank    (coef_bank),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] x, output logic [15:0] y,
                                 output int lat, output logic bank_after);
        int w = 0;
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        checkOutput("s_ready before accept", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = x;
        @(negedge clk);
        s_valid    = 1'b0;
        s_data     = '0;
        bank_after = coef_bank;
        lat        = 1;
        while (!m_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        y = m_data;
    endtask

    task automatic writeCoef(input logic [6:0] addr, input logic [15:0] data);
        coef_wr_en   = 1'b1;
        coef_wr_addr = addr;
        coef_wr_data = data;
        @(negedge clk);
        coef_wr_en   = 1'b0;
    endtask

    task automatic pulseSwap();
        coef_swap = 1'b1;
        @(negedge clk);
        coef_swap = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("s_ready in reset", 32'(s_ready), 32'd0);
        checkOutput("m_valid in reset", 32'(m_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset s_ready", 32'(s_ready), 32'd1);
        checkOutput("reset m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset m_data", 32'(m_data), 32'd0);
        checkOutput("reset coef_bank", 32'(coef_bank), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
    endtask

    task automatic runTable(input int count, input string tag);
        logic [15:0] y;
        int          lat;
        logic        b;
        for (int i = 0; i < count; i++) begin
            applyStimulus(vecs[i].sample, y, lat, b);
            if (vecs[i].check) begin
                checkOutput($sformatf("%s out[%0d]", tag, i), 32'(y), 32'(vecs[i].expect_y));
                checkOutput($sformatf("%s latency[%0d]", tag, i), 32'(lat), 32'd77);
            end
        end
    endtask

    task automatic fillCentre();
        for (int i = 0; i < 76; i++)
            vecs[i] = '{sample: (i == 0) ? 16'h4000 : 16'h0000,
                        expect_y: (i == 73) ? 16'h2000 : 16'h0000, check: 1'b1};
    endtask

    initial begin
        logic [15:0] y;
        logic [15:0] held;
        int          lat;
        logic        b;
        logic        seen;

        doReset();

        // Centre tap only; the out-of-range write must not disturb anything.
        writeCoef(7'd73, 16'h4000);
        writeCoef(7'd74, 16'h7FFF);
        pulseSwap();
        checkOutput("centre bank swapped", 32'(coef_bank), 32'd1);
        fillCentre();
        runTable(76, "centre");

        doReset();
        writeCoef(7'd0, 16'h2000);
        pulseSwap();
        for (int i = 0; i < 147; i++)
            vecs[i] = '{sample: (i == 0) ? 16'h4000 : 16'h0000,
                        expect_y: (i == 0 || i == 146) ? 16'h1000 : 16'h0000, check: 1'b1};
        runTable(147, "pair");

        doReset();
        for (int a = 0; a < 74; a++)
            writeCoef(7'(a), 16'h7FFF);
        pulseSwap();
        for (int i = 0; i < 294; i++)
            vecs[i] = '{sample: (i < 147) ? 16'h7FFF : 16'h8000,
                        expect_y: (i == 0) ? 16'h7FFE : ((i < 147) ? 16'h7FFF : 16'h8000),
                        check: (i == 0 || i == 146 || i == 293)};
        runTable(294, "sat");

        // Swap requested mid-sample, together with a write and a redundant second request.
        doReset();
        writeCoef(7'd73, 16'h4000);
        pulseSwap();
        checkOutput("swap bank A active", 32'(coef_bank), 32'd1);
        for (int i = 0; i < 74; i++)
            vecs[i] = '{sample: 16'h4000, expect_y: (i == 73) ? 16'h2000 : 16'h0000, check: 1'b1};
        runTable(74, "prefill");

        @(negedge clk);
        checkOutput("swap s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = 16'h4000;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (5) @(negedge clk);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 7'd73;
        coef_wr_data = 16'h7FFF;
        coef_swap    = 1'b1;
        @(negedge clk);
        coef_wr_en = 1'b0;
        coef_swap  = 1'b0;
        @(negedge clk);
        coef_swap  = 1'b1;
        @(negedge clk);
        coef_swap  = 1'b0;
        checkOutput("bank held mid-sample", 32'(coef_bank), 32'd1);
        lat = 9;
        while (!m_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("swap current latency", 32'(lat), 32'd77);
        checkOutput("swap current out", 32'(m_data), 32'h2000);
        checkOutput("swap current bank", 32'(coef_bank), 32'd1);

        @(negedge clk);
        checkOutput("bank before accept", 32'(coef_bank), 32'd1);
        m_ready = 1'b0;
        applyStimulus(16'h4000, y, lat, b);
        checkOutput("bank on accept edge", 32'(b), 32'd0);
        checkOutput("swap next out", 32'(y), 32'h4000);
        checkOutput("swap next latency", 32'(lat), 32'd77);

        held = y;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("bp m_valid[%0d]", c), 32'(m_valid), 32'd1);
            checkOutput($sformatf("bp m_data[%0d]", c), 32'(m_data), 32'(held));
            checkOutput($sformatf("bp s_ready[%0d]", c), 32'(s_ready), 32'd0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp single result", 32'(m_valid), 32'd0);
        checkOutput("bp busy idle", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("single swap only", 32'(coef_bank), 32'd0);

        // Reset 30 cycles into MAC must suppress the in-flight result.
        s_valid = 1'b1;
        s_data  = 16'h4000;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("mid-MAC busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid-MAC reset m_valid", 32'(m_valid), 32'd0);
        checkOutput("mid-MAC reset s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (m_valid)
                seen = 1'b1;
        end
        checkOutput("no partial result", 32'(seen), 32'd0);
        checkOutput("mid-MAC reset bank", 32'(coef_bank), 32'd0);
        checkOutput("mid-MAC reset busy", 32'(busy), 32'd0);

        writeCoef(7'd73, 16'h4000);
        pulseSwap();
        fillCentre();
        runTable(76, "rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
